irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  Interrupt front-end feeding the CPU pipeline's CP0/ID stage (replaces the bare interrupt_driver hookup).
//  Synchronises async io interrupt lines, latches rising edges as pending, applies mask/global disable and
//  fixed priority, and presents one vectored request per ack handshake; tracks in-service lines until eret.
// PARAMETERS
//  NUM_IRQ      3            number of interrupt lines; higher index = higher priority
//  SYNC_STAGES  2            synchroniser flops per line (>=2)
//  VEC_BASE     32'h0000_0400  vector of highest-priority line (NUM_IRQ-1)
//  VEC_STRIDE   32'h0000_0200  vector(i) = VEC_BASE + (NUM_IRQ-1-i)*VEC_STRIDE  (3 lines: 0x400/0x600/0x800)
// PORTS
//  clk           in   1        pipeline clock (gated clk, stops on halt)
//  rst_n         in   1        asynchronous reset, active-low
//  irq_in        in   NUM_IRQ  async level interrupt lines from io
//  irq_mask_i    in   NUM_IRQ  CP0 mask reg; 1 = line enabled
//  int_disable_i in   1        CP0 global disable; 1 = no new requests
//  irq_ack_i     in   1        1-cycle pulse: pipeline redirected pc to irq_vec_o and wrote EPC
//  eret_i        in   1        1-cycle pulse: exception return retired in ID
//  irq_req_o     out  1        request valid (registered)
//  irq_id_o      out  clog2(NUM_IRQ)  index of requested line
//  irq_vec_o     out  32       handler entrance address for irq_id_o
//  pending_o     out  NUM_IRQ  latched pending bits (CP0 read-back)
//  in_service_o  out  NUM_IRQ  lines currently in handler
// BEHAVIOUR
//  - Reset (async, rst_n=0): all sync flops, pending, in_service, state=IDLE; irq_req_o=0, irq_id_o=0, irq_vec_o=0.
//  - Edge: sync[i] & ~sync_d[i] sets pending[i]; levels held high do not re-set after clearing.
//  - Latency: irq_in rises before edge 1 -> pending at edge SYNC_STAGES+1 -> irq_req_o=1 after edge SYNC_STAGES+2.
//  - eligible = pending & irq_mask_i & ~{NUM_IRQ{int_disable_i}} & lines above current level; winner = highest index.
//  - Current level = highest set in_service bit; none set -> all lines above level.
//  - FSM IDLE: eligible!=0 -> REQ, latch irq_id_o/irq_vec_o of winner, irq_req_o=1.
//    REQ: id/vec/req frozen until irq_ack_i (no preemption, no withdrawal on mask/disable change).
//      on ack: pending[id]<=0, in_service[id]<=1, irq_req_o<=0, -> SERVICE.
//    SERVICE: eret_i clears highest in_service bit; none left -> IDLE; new eligible handled per CONFIGURATION.
//  - irq_ack_i outside REQ and eret_i with in_service==0: ignored, no state change.
//  - Same cycle: new edge and ack on same line -> pending stays 1 (set wins); eret and ack -> eret clears
//    highest bit of the pre-ack in_service, then ack sets in_service[id].
//  - Masked/disabled pending bits are retained, not dropped; they request once re-enabled.
// CONFIGURATION
//  IRQ_NESTING_EN defined: in SERVICE (or IDLE), eligible line strictly above current level -> REQ;
//    in_service may hold several bits; eret unwinds highest first.
//  IRQ_NESTING_EN undefined: any in_service bit blocks all requests; at most one bit set; SERVICE exits
//    only via eret -> IDLE, then re-arbitrates next cycle.
// STRUCTURE
//  Package irq_pkg: state enum {IDLE,REQ,SERVICE}, default VEC_BASE/VEC_STRIDE constants,
//    function prio_enc(vec) returning highest set index and valid.
//  Sub-module irq_sync_edge (one per line via generate): SYNC_STAGES synchroniser + delayed copy,
//    outputs 1-cycle rise pulse; async reset to 0.
//  Top: pending/in_service regs, arbiter (prio_enc), FSM, vector arithmetic (32-bit, mod 2^32).
// TESTING
//  1 irq_in[0] pulse 3 cycles, mask=3'b111, disable=0 -> irq_req_o=1 after edge 4, id=0, vec=0x800; ack -> pending_o=0, in_service_o=3'b001.
//  2 irq_in[0] and irq_in[2] rise same cycle -> first req id=2 vec=0x400; ack+eret -> second req id=0 vec=0x800.
//  3 mask=3'b101, irq_in[1] rises -> no req, pending_o=3'b010; set mask=3'b111 -> req id=1 vec=0x600 next edge+1.
//  4 in SERVICE id=0, irq_in[2] rises -> with IRQ_NESTING_EN req id=2, in_service_o=3'b101 after ack, eret -> 3'b001;
//    without -> no req until eret, then req id=2.
//  5 disable=1 while REQ id=1 -> req/id/vec stay stable until ack; new edge on line 0 stays pending.
//  6 rst_n=0 mid-REQ (async, between edges) -> irq_req_o, pending_o, in_service_o = 0 immediately; no req after release.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//   Shared types and helpers for the interrupt front-end.
//   - state_e   : request FSM states
//   - prio_t    : priority-encoder result (valid + index)
//   - prio_enc  : highest set bit of a vector of up to 32 lines
//   - VEC_BASE_DEF / VEC_STRIDE_DEF : default handler vector layout
// ---------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0400;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0200;

    // Encoder works on a 32-bit view, so NUM_IRQ is limited to 32 lines.
    localparam int PRIO_W = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } prio_t;

    // Highest set index wins; ascending scan lets the last hit overwrite.
    function automatic prio_t prio_enc(input logic [PRIO_W-1:0] vec);
        prio_t r;
        r = '0;
        for (int i = 0; i < PRIO_W; i++) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// ---------------------------------------------------------------------------
// irq_controller_if
//   Vectored request / acknowledge handshake between the interrupt
//   controller and the pipeline CP0/ID stage.
//   irq_req  : request valid (controller -> pipeline)
//   irq_id   : index of requested line
//   irq_vec  : handler entrance address
//   irq_ack  : 1-cycle pulse, pipeline took the interrupt (pipeline -> ctrl)
//   eret     : 1-cycle pulse, exception return retired
//   modport master = controller side, slave = pipeline side.
// ---------------------------------------------------------------------------
interface irq_controller_if #(
    parameter int NUM_IRQ = 3
);
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic [31:0]     irq_vec;
    logic            irq_ack;
    logic            eret;

    modport master (
        output irq_req, irq_id, irq_vec,
        input  irq_ack, eret
    );

    modport slave (
        input  irq_req, irq_id, irq_vec,
        output irq_ack, eret
    );

endinterface

// File: rtl/irq_controller_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
//   Per-line synchroniser and rising-edge detector.
//   clk, rst_n : clock, async active-low reset (chain clears to 0)
//   async_i    : asynchronous level input
//   rise_o     : 1-cycle pulse when the synchronised level goes 0 -> 1
//   chain_q[SYNC_STAGES-1] is the synchronised level; the extra top stage is
//   its one-cycle delayed copy used for edge detection.
// ---------------------------------------------------------------------------
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_q <= '0;
        else        chain_q <= {chain_q[SYNC_STAGES-1:0], async_i};
    end

    assign rise_o = chain_q[SYNC_STAGES-1] & ~chain_q[SYNC_STAGES];

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Interrupt front-end for the CP0/ID stage. Synchronises io lines, latches
//   rising edges as pending, applies mask / global disable / fixed priority
//   (higher index wins) and presents one vectored request per ack. Tracks
//   lines in service until eret.
//
//   Ports:
//     clk, rst_n     : pipeline clock, async active-low reset
//     irq_in         : async level interrupt lines
//     irq_mask_i     : per-line enable (1 = enabled)
//     int_disable_i  : global disable of new requests
//     bus (master)   : irq_req/irq_id/irq_vec out, irq_ack/eret in
//     pending_o      : latched pending bits
//     in_service_o   : lines currently in a handler
//
//   Build option: define IRQ_NESTING_EN to let a strictly higher-priority
//   line preempt a running handler. Default build: any line in service
//   blocks all new requests.
// ---------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ     = 3,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE  = VEC_STRIDE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [NUM_IRQ-1:0]  irq_mask_i,
    input  logic                int_disable_i,
    irq_controller_if.master    bus,
    output logic [NUM_IRQ-1:0]  pending_o,
    output logic [NUM_IRQ-1:0]  in_service_o
);

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    // ------------------------------------------------------------------
    // Edge detection, one synchroniser per line
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] rise;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .async_i (irq_in[g]),
            .rise_o  (rise[g])
        );
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,      state_d;
    logic [NUM_IRQ-1:0] pending_q,    pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic               req_q,        req_d;
    logic [ID_W-1:0]    id_q,         id_d;
    logic [31:0]        vec_q,        vec_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    prio_t              lvl;        // current level = highest in-service line
    prio_t              win;        // winning eligible line
    logic [NUM_IRQ-1:0] above;      // lines allowed by the current level
    logic [NUM_IRQ-1:0] eligible;
    logic [31:0]        win_vec;

    always_comb begin
        lvl = prio_enc(32'(in_service_q));
`ifdef IRQ_NESTING_EN
        above = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            above[i] = !lvl.valid || (5'(i) > lvl.idx);
        end
`else
        // Any handler running blocks every line.
        above = lvl.valid ? '0 : '1;
`endif
        eligible = pending_q & irq_mask_i & ~{NUM_IRQ{int_disable_i}} & above;
        win      = prio_enc(32'(eligible));
        win_vec  = VEC_BASE + (32'(NUM_IRQ - 1) - 32'(win.idx)) * VEC_STRIDE;
    end

    // ------------------------------------------------------------------
    // Pending / in-service bookkeeping
    // ------------------------------------------------------------------
    logic               ack_fire;
    logic               eret_fire;
    logic [NUM_IRQ-1:0] id_oh;
    logic [NUM_IRQ-1:0] lvl_oh;
    logic [NUM_IRQ-1:0] svc_after_eret;

    always_comb begin
        ack_fire  = (state_q == REQ) && bus.irq_ack;
        eret_fire = bus.eret && lvl.valid;
        id_oh     = NUM_IRQ'(1) << id_q;
        lvl_oh    = NUM_IRQ'(1) << lvl.idx;

        // A fresh edge in the ack cycle re-arms the line: set wins over clear.
        pending_d = (pending_q & ~(ack_fire ? id_oh : '0)) | rise;

        // eret unwinds the pre-ack level before ack adds the new line.
        svc_after_eret = in_service_q & ~(eret_fire ? lvl_oh : '0);
        in_service_d   = svc_after_eret | (ack_fire ? id_oh : '0);
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (win.valid) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    id_d    = win.idx[ID_W-1:0];
                    vec_d   = win_vec;
                end
            end
            // Request is frozen until taken; mask/disable changes do not
            // withdraw it.
            REQ: begin
                if (ack_fire) begin
                    state_d = SERVICE;
                    req_d   = 1'b0;
                end
            end
            SERVICE: begin
`ifdef IRQ_NESTING_EN
                if (win.valid) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    id_d    = win.idx[ID_W-1:0];
                    vec_d   = win_vec;
                end else if (eret_fire && (svc_after_eret == '0)) begin
                    state_d = IDLE;
                end
`else
                if (eret_fire && (svc_after_eret == '0)) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            in_service_q <= '0;
            req_q        <= 1'b0;
            id_q         <= '0;
            vec_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            req_q        <= req_d;
            id_q         <= id_d;
            vec_q        <= vec_d;
        end
    end

    assign bus.irq_req  = req_q;
    assign bus.irq_id   = id_q;
    assign bus.irq_vec  = vec_q;
    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule
